// File: rtl/stock_pkg.sv
// Shared types for the stock controller: command opcodes, response status and FSM states.
package stock_pkg;

    typedef enum logic [1:0] {
        OP_ADD    = 2'd0,
        OP_REMOVE = 2'd1,
        OP_QUERY  = 2'd2,
        OP_CLEAR  = 2'd3
    } op_t;

    typedef enum logic [1:0] {
        ST_OK     = 2'd0,
        ST_SAT_HI = 2'd1,
        ST_SAT_LO = 2'd2
    } status_t;

    typedef enum logic [2:0] {
        S_INIT   = 3'd0,
        S_IDLE   = 3'd1,
        S_READ   = 3'd2,
        S_MODIFY = 3'd3,
        S_RESP   = 3'd4
    } state_t;

endpackage

// File: rtl/stock_ram.sv
// Single-port quantity store, DEPTH x DATA_W, synchronous read.
module stock_ram #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/stock_ctrl.sv
// Inventory controller: post-reset RAM clear, then read-modify-write of one
// item quantity per command with saturating add/remove.
module stock_ctrl
    import stock_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  op_t               cmd_op,
    input  logic [ADDR_W-1:0] cmd_code,
    input  logic [DATA_W-1:0] cmd_quant,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_quant,
    output status_t           rsp_status,
    output logic              busy_init
);

    state_t            state;
    logic [ADDR_W-1:0] init_cnt;
    op_t               op_q;
    logic [ADDR_W-1:0] code_q;
    logic [DATA_W-1:0] quant_q;

    logic              ram_we_c;
    logic [ADDR_W-1:0] ram_addr_c;
    logic [DATA_W-1:0] ram_wdata_c;
    logic [DATA_W-1:0] ram_rdata;

    logic [DATA_W:0]   sum_c;
    logic [DATA_W-1:0] new_c;
    status_t           status_c;

    stock_ram #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we_c),
        .addr  (ram_addr_c),
        .wdata (ram_wdata_c),
        .rdata (ram_rdata)
    );

    // Saturating ALU on the freshly read quantity
    always_comb begin
        sum_c    = {1'b0, ram_rdata} + {1'b0, quant_q};
        new_c    = ram_rdata;
        status_c = ST_OK;
        case (op_q)
            OP_ADD: begin
                if (sum_c[DATA_W]) begin
                    new_c    = '1;
                    status_c = ST_SAT_HI;
                end else begin
                    new_c = sum_c[DATA_W-1:0];
                end
            end
            OP_REMOVE: begin
                if (quant_q > ram_rdata) begin
                    new_c    = '0;
                    status_c = ST_SAT_LO;
                end else begin
                    new_c = ram_rdata - quant_q;
                end
            end
            OP_QUERY: new_c = ram_rdata;
            OP_CLEAR: new_c = '0;
            default:  new_c = ram_rdata;
        endcase
    end

    // RAM port mux; writes are gated by rst_n so a reset cycle never commits one
    always_comb begin
        ram_addr_c  = code_q;
        ram_wdata_c = new_c;
        ram_we_c    = 1'b0;
        if (state == S_INIT) begin
            ram_addr_c  = init_cnt;
            ram_wdata_c = '0;
            ram_we_c    = rst_n;
        end else if (state == S_MODIFY && op_q != OP_QUERY) begin
            ram_we_c = rst_n;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= S_INIT;
            init_cnt   <= '0;
            op_q       <= OP_ADD;
            code_q     <= '0;
            quant_q    <= '0;
            cmd_ready  <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_quant  <= '0;
            rsp_status <= ST_OK;
            busy_init  <= 1'b1;
        end else begin
            case (state)
                S_INIT: begin
                    init_cnt <= init_cnt + ADDR_W'(1);
                    if (init_cnt == '1) begin
                        state     <= S_IDLE;
                        busy_init <= 1'b0;
                        cmd_ready <= 1'b1;
                    end
                end
                S_IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        op_q      <= cmd_op;
                        code_q    <= cmd_code;
                        quant_q   <= cmd_quant;
                        cmd_ready <= 1'b0;
                        state     <= S_READ;
                    end
                end
                S_READ: state <= S_MODIFY;
                S_MODIFY: begin
                    rsp_quant  <= new_c;
                    rsp_status <= status_c;
                    rsp_valid  <= 1'b1;
                    state      <= S_RESP;
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        cmd_ready <= 1'b1;
                        state     <= S_IDLE;
                    end
                end
                default: begin
                    state     <= S_INIT;
                    init_cnt  <= '0;
                    cmd_ready <= 1'b0;
                    rsp_valid <= 1'b0;
                    busy_init <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: doc/stock_ctrl.md
# stock_ctrl

Parametrised, clocked inventory controller: holds one quantity per item code in internal RAM and executes add, remove, query and clear commands as read-modify-write transactions with saturating arithmetic. It replaces the unclocked save/submit inventory core. Commands arrive over a valid/ready handshake; results and status are returned over a second one. It sits between the front-panel/command decoder and the display logic.

## Interface
- DATA_W, 8, quantity width in bits
- ADDR_W, 8, item-code width; DEPTH = 2**ADDR_W entries

- clk  in  1  single clock, all logic on rising edge
- rst_n  in  1  reset, synchronous, active-low
- cmd_valid  in  1  command present
- cmd_ready  out  1  block accepts command this cycle
- cmd_op  in  2  stock_pkg::op_t: OP_ADD=0, OP_REMOVE=1, OP_QUERY=2, OP_CLEAR=3
- cmd_code  in  ADDR_W  item address
- cmd_quant  in  DATA_W  operand (ignored for QUERY/CLEAR)
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer takes response
- rsp_quant  out  DATA_W  stored quantity after the operation
- rsp_status  out  2  stock_pkg::status_t: ST_OK=0, ST_SAT_HI=1, ST_SAT_LO=2
- busy_init  out  1  high while post-reset RAM clear runs

## Operation
- FSM states: INIT, IDLE, READ, MODIFY, RESP.
- INIT: entered on reset; counter walks addresses 0..DEPTH-1 writing 0, one per cycle; busy_init=1, cmd_ready=0; leaves to IDLE after writing DEPTH-1.
- IDLE: cmd_ready=1. On cmd_valid&&cmd_ready latch op/code/quant, go READ.
- READ: present code to RAM (sync read), go MODIFY.
- MODIFY: old = RAM data. Compute in DATA_W+1 bits:
  - ADD: sum = old + quant; if sum > 2**DATA_W-1 then new = all ones, ST_SAT_HI; else new = sum, ST_OK.
  - REMOVE: if quant > old then new = 0, ST_SAT_LO; else new = old - quant, ST_OK.
  - QUERY: new = old, no write, ST_OK.
  - CLEAR: new = 0, ST_OK.
  - Write new (except QUERY); register rsp_quant=new, rsp_status; go RESP.
- RESP: rsp_valid=1, outputs stable; on rsp_ready go IDLE.
- Reset values: cmd_ready=0, rsp_valid=0, rsp_quant=0, rsp_status=ST_OK, busy_init=1 (state INIT).
- Reset mid-operation: command dropped, no pending write committed after reset cycle, no response produced; INIT restarts from address 0.
- cmd_* inputs are ignored outside IDLE; operands are latched, so changes after acceptance have no effect.

## Timing
- Accept at edge T0 (IDLE), READ at T1, RAM data and write at T2 (MODIFY), rsp_valid high from T3.
- Minimum command-to-response latency 3 cycles; minimum issue interval 4 cycles (RESP with rsp_ready=1 takes 1 cycle).
- rsp_valid holds indefinitely without rsp_ready; cmd_ready stays 0 meanwhile.
- Back-to-back commands on the same code see the previous write (write committed at T2, next read no earlier than T5).
- INIT lasts exactly DEPTH cycles after rst_n deasserts; cmd_ready rises the cycle after.

## Structure
- stock_pkg: op_t, status_t enums, state_t enum for the FSM.
- Sub-module stock_ram: single-port, DEPTH x DATA_W, synchronous read, write-first irrelevant (no same-cycle read/write of one address); parameters DATA_W, ADDR_W.
- stock_ctrl: FSM, INIT counter, operand registers, saturating ALU, response registers.

## Test plan
- Reset, hold rst_n=1 for DEPTH cycles -> busy_init falls after 256 cycles; QUERY code 0x10 -> rsp_quant=0, ST_OK.
- ADD code 0x05 quant 200, then ADD quant 100 -> responses 200/ST_OK then 255/ST_SAT_HI; QUERY -> 255.
- REMOVE code 0x05 quant 55 after value 255 -> 200/ST_OK; REMOVE 250 -> 0/ST_SAT_LO.
- ADD 0x07 quant 9 with rsp_ready=0 for 10 cycles -> rsp_valid, rsp_quant=9 stable, cmd_ready=0 throughout; one response only after rsp_ready.
- CLEAR code 0x05 after value 40 -> 0/ST_OK; neighbouring code 0x06 unchanged.
- Assert rst_n=0 during MODIFY of ADD 0x09 quant 3 -> no rsp_valid, INIT reruns, QUERY 0x09 -> 0.
